// File: rtl/approx_wallace_mac_pkg.sv
// Shared definitions for the approximate Wallace multiply-accumulate block:
// product mode encoding and partial-product column geometry.
package approx_wallace_mac_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Number of partial-product bits a[i]&b[j] with i+j == k for an n x n multiply.
  function automatic int col_height(input int width, input int k);
    if (k < 0 || k > 2 * width - 2) begin
      return 0;
    end else if (k < width) begin
      return k + 1;
    end else begin
      return 2 * width - 1 - k;
    end
  endfunction

endpackage

// File: rtl/approx_wallace_mac_column_compressor.sv
// Combinational partial-product compressor: reduces the a*b matrix to a sum row and a
// carry row, replacing the low APPROX_COLS columns with a carry-free OR in approximate mode.
module approx_column_compressor
  import approx_wallace_mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 5
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic [2*WIDTH-1:0] sum_row,
  output logic [2*WIDTH-1:0] carry_row
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] LOW_MASK =
    (APPROX_COLS == 0) ? '0 : ({PW{1'b1}} >> (PW - APPROX_COLS));

  logic [PW-2:0] col_or;
  logic [PW-1:0] approx_sel;
  logic [PW-1:0] row;
  logic [PW-1:0] s;
  logic [PW-1:0] c;
  logic [PW-1:0] nc;

  for (genvar k = 0; k < PW - 1; k++) begin : g_col
    localparam int H   = col_height(WIDTH, k);
    localparam int ILO = (k < WIDTH) ? 0 : k - WIDTH + 1;
    logic [H-1:0] bits;
    for (genvar n = 0; n < H; n++) begin : g_bit
      assign bits[n] = a[ILO+n] & b[k-ILO-n];
    end
    assign col_or[k] = |bits;
  end

  assign approx_sel = (mode == MODE_APPROX) ? LOW_MASK : '0;

  // Carry-save reduction of the exact columns only; carries move strictly upward,
  // so the approximated low columns of s and c stay zero and can take the OR bits.
  always_comb begin
    s   = '0;
    c   = '0;
    row = '0;
    nc  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = (PW'(b) << i) & {PW{a[i]}} & ~approx_sel;
      nc  = ((s & c) | (s & row) | (c & row)) << 1;
      s   = s ^ c ^ row;
      c   = nc;
    end
    sum_row   = s | (approx_sel & {1'b0, col_or});
    carry_row = c;
  end

endmodule

// File: rtl/approx_wallace_mac.sv
// Two-stage multiply-accumulate: stage 1 registers the compressed partial sums,
// stage 2 does the final add and a saturating accumulate, with ready/valid backpressure.
module approx_wallace_mac
  import approx_wallace_mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 5,
  parameter int ACC_W       = 2 * WIDTH + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic [15:0]      out_count
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    comp_sum;
  logic [PW-1:0]    comp_carry;
  logic             stall;

  logic             s1_valid_d, s1_valid_q;
  logic             s1_clr_d, s1_clr_q;
  logic             s1_mode_d, s1_mode_q;
  logic [PW-1:0]    s1_sum_d, s1_sum_q;
  logic [PW-1:0]    s1_carry_d, s1_carry_q;

  logic             out_valid_d, out_valid_q;
  logic [ACC_W-1:0] out_acc_d, out_acc_q;
  logic             out_sat_d, out_sat_q;
  logic [15:0]      out_count_d, out_count_q;

  logic [PW-1:0]    product;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic             overflow;

  approx_column_compressor #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_compressor (
    .a         (in_a),
    .b         (in_b),
    .mode      (in_mode),
    .sum_row   (comp_sum),
    .carry_row (comp_carry)
  );

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_clr_d   = s1_clr_q;
    s1_mode_d  = s1_mode_q;
    s1_sum_d   = s1_sum_q;
    s1_carry_d = s1_carry_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_clr_d   = in_clr;
        s1_mode_d  = in_mode;
        s1_sum_d   = comp_sum;
        s1_carry_d = comp_carry;
      end
    end
  end

  // The mode has already shaped the compressed rows; it travels with the beat for observability.
  always_comb begin
    product     = s1_sum_q + s1_carry_q;
    acc_base    = s1_clr_q ? '0 : out_acc_q;
    acc_sum     = {1'b0, acc_base} + (ACC_W + 1)'(product);
    overflow    = acc_sum[ACC_W];
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    if (!stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_acc_d   = overflow ? '1 : acc_sum[ACC_W-1:0];
        out_sat_d   = (s1_clr_q ? 1'b0 : out_sat_q) | overflow;
        out_count_d = s1_clr_q ? 16'd1 : out_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_clr_q   <= s1_clr_d;
    s1_mode_q  <= s1_mode_d;
    s1_sum_q   <= s1_sum_d;
    s1_carry_q <= s1_carry_d;
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

  // Keeps the carried mode bit referenced; it has no effect on the datapath.
  logic unused_mode;
  assign unused_mode = s1_mode_q;

endmodule

// File: tb/tb_approx_wallace_mac.sv
// Directed bench for approx_wallace_mac (WIDTH=8, APPROX_COLS=5, ACC_W=16):
// table of single beats, then backpressure and mid-flight reset sequences.
module tb_approx_wallace_mac;

  localparam int WIDTH       = 8;
  localparam int APPROX_COLS = 5;
  localparam int ACC_W       = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_sat;
  logic [15:0]      out_count;

  always #5 clk = ~clk;

  approx_wallace_mac #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS),
    .ACC_W       (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode;
    logic        clr;
    logic [15:0] acc;
    logic [15:0] count;
    logic        sat;
  } vec_t;

  vec_t vecs [12];
  int   passCount  = 0;
  int   checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Entered and left at posedge+1; one beat, result checked exactly two edges later.
  task automatic applyStimulus(input vec_t v, input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_mode   = v.mode;
    in_clr    = v.clr;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " acc"}, 32'(out_acc), 32'(v.acc));
    checkOutput({tag, " count"}, 32'(out_count), 32'(v.count));
    checkOutput({tag, " sat"}, 32'(out_sat), 32'(v.sat));
    @(posedge clk); #1;
    checkOutput({tag, " valid drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " acc hold"}, 32'(out_acc), 32'(v.acc));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent, recv, stallCnt, cyc;
    logic [15:0] bpAcc [4];
    vec_t v;

    vecs[0]  = '{8'd3,   8'd3,   1'b0, 1'b1, 16'd9,     16'd1, 1'b0};
    vecs[1]  = '{8'd3,   8'd3,   1'b1, 1'b1, 16'd7,     16'd1, 1'b0};
    vecs[2]  = '{8'd255, 8'd255, 1'b1, 1'b1, 16'd64927, 16'd1, 1'b0};
    vecs[3]  = '{8'd10,  8'd10,  1'b0, 1'b1, 16'd100,   16'd1, 1'b0};
    vecs[4]  = '{8'd4,   8'd5,   1'b0, 1'b0, 16'd120,   16'd2, 1'b0};
    vecs[5]  = '{8'd2,   8'd3,   1'b0, 1'b0, 16'd126,   16'd3, 1'b0};
    vecs[6]  = '{8'd255, 8'd255, 1'b0, 1'b1, 16'd65025, 16'd1, 1'b0};
    vecs[7]  = '{8'd255, 8'd255, 1'b0, 1'b0, 16'd65535, 16'd2, 1'b1};
    vecs[8]  = '{8'd1,   8'd1,   1'b0, 1'b1, 16'd1,     16'd1, 1'b0};
    vecs[9]  = '{8'd5,   8'd7,   1'b1, 1'b0, 16'd32,    16'd2, 1'b0};
    vecs[10] = '{8'd0,   8'd200, 1'b1, 1'b0, 16'd32,    16'd3, 1'b0};
    vecs[11] = '{8'd16,  8'd16,  1'b1, 1'b0, 16'd288,   16'd4, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    in_clr    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset acc", 32'(out_acc), 32'd0);
    checkOutput("reset count", 32'(out_count), 32'd0);
    checkOutput("reset sat", 32'(out_sat), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Four back-to-back beats; the consumer refuses the first result for three cycles.
    bpAcc[0] = 16'd1;
    bpAcc[1] = 16'd5;
    bpAcc[2] = 16'd14;
    bpAcc[3] = 16'd30;
    sent     = 0;
    recv     = 0;
    stallCnt = 0;
    cyc      = 0;
    while (recv < 4 && cyc < 50) begin
      @(posedge clk); #1;
      in_valid  = (sent < 4);
      in_a      = 8'(sent + 1);
      in_b      = 8'(sent + 1);
      in_mode   = 1'b0;
      in_clr    = (sent == 0);
      out_ready = (stallCnt >= 3);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        checkOutput($sformatf("bp stall%0d in_ready", stallCnt), 32'(in_ready), 32'd0);
        checkOutput($sformatf("bp stall%0d acc", stallCnt), 32'(out_acc), 32'(bpAcc[recv]));
        checkOutput($sformatf("bp stall%0d count", stallCnt), 32'(out_count), 32'(recv + 1));
        stallCnt++;
      end else if (out_valid && out_ready) begin
        checkOutput($sformatf("bp r%0d acc", recv), 32'(out_acc), 32'(bpAcc[recv]));
        checkOutput($sformatf("bp r%0d count", recv), 32'(out_count), 32'(recv + 1));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    checkOutput("bp results delivered", 32'(recv), 32'd4);
    checkOutput("bp stall cycles", 32'(stallCnt), 32'd3);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp no dup %0d", i), 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Reset with one beat in the output stage, one in stage 1 and one being offered.
    v = '{8'd9, 8'd9, 1'b0, 1'b1, 16'd81, 16'd1, 1'b0};
    applyStimulus(v, "rst pre");
    in_valid = 1'b1;
    in_a     = 8'd1;
    in_b     = 8'd1;
    in_clr   = 1'b0;
    in_mode  = 1'b0;
    @(posedge clk); #1;
    in_a = 8'd2;
    in_b = 8'd2;
    @(posedge clk); #1;
    checkOutput("rst inflight acc", 32'(out_acc), 32'd82);
    checkOutput("rst inflight count", 32'(out_count), 32'd2);
    rst_n = 1'b0;
    in_a  = 8'd3;
    in_b  = 8'd3;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst acc", 32'(out_acc), 32'd0);
    checkOutput("rst count", 32'(out_count), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rst no stale %0d", i), 32'(out_valid), 32'd0);
    end
    v = '{8'd3, 8'd4, 1'b0, 1'b0, 16'd12, 16'd1, 1'b0};
    applyStimulus(v, "rst post");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/approx_wallace_mac.md
APPROX_WALLACE_MAC -- requirements
Module: approx_wallace_mac

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal values are 4 to 16.
REQ-002 Parameter APPROX_COLS, default 5, SHALL set the number of low product columns (weights 2^0..2^(APPROX_COLS-1)) that are approximated; legal values are 0 to 2*WIDTH-1.
REQ-003 Parameter ACC_W, default 2*WIDTH+8, SHALL set the accumulator width; it must be at least 2*WIDTH.
REQ-004 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  an operand beat is present.
REQ-007 in_ready  output  1  the block can accept a beat this cycle.
REQ-008 in_a, in_b  input  WIDTH each  unsigned operands.
REQ-009 in_mode  input  1  0 = exact product, 1 = approximate product.
REQ-010 in_clr  input  1  this beat starts a new accumulation.
REQ-011 out_valid  output  1  the accumulator result is present.
REQ-012 out_ready  input  1  the consumer accepts the result.
REQ-013 out_acc  output  ACC_W  running accumulated sum.
REQ-014 out_sat  output  1  sticky flag: saturation has occurred since the last clear.
REQ-015 out_count  output  16  number of beats accumulated since the last clear; wraps modulo 2^16.

Function
REQ-016 Partial product pp[i][j] SHALL equal in_a[i] AND in_b[j], contributing to column k = i + j.
REQ-017 In exact mode, the product SHALL equal in_a * in_b.
REQ-018 In approximate mode, each column k < APPROX_COLS SHALL contribute (OR of its pp bits) * 2^k and generate no carry; each column k >= APPROX_COLS SHALL contribute (sum of its pp bits) * 2^k.
REQ-019 Stage 1 SHALL register the column-compressed partial sums together with a valid bit, mode and clr; stage 2 SHALL perform the final add and the accumulate into the output register.
REQ-020 A beat transfers when in_valid and in_ready are both 1; its result SHALL appear with out_valid = 1 exactly 2 cycles later when there is no stall.
REQ-021 Stall = out_valid AND NOT out_ready; during a stall, both stages and all outputs SHALL hold, and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-022 When stage 1 holds valid data and there is no stall, the update SHALL be: acc = (clr ? 0 : acc) + product, saturating at 2^ACC_W-1.
REQ-023 out_sat SHALL be set when a saturation occurs, cleared by a clr beat, and set again if that clr beat itself saturates.
REQ-024 out_count SHALL become 1 on a clr beat and otherwise increment by 1 per accumulated beat.
REQ-025 When there is no stall and stage 1 is empty, out_valid SHALL drop to 0 and out_acc, out_sat and out_count SHALL hold.
REQ-026 A stall SHALL never drop or duplicate a beat; back-to-back beats SHALL sustain a throughput of one per cycle.

Reset
REQ-027 While rst_n = 0 at a clock edge, the following SHALL be cleared: both stage valid bits, out_valid, out_acc, out_sat and out_count; in_ready SHALL be 1 in the cycle after reset.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight beats; beats transferred in the reset cycle SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the mode encoding constants (MODE_EXACT = 0, MODE_APPROX = 1) and a function returning the column height for a given WIDTH and k.
REQ-030 The column compression SHALL be a single combinational sub-module, approx_column_compressor, parametrised by WIDTH and APPROX_COLS.

Verification (WIDTH=8, APPROX_COLS=5 unless stated)
REQ-031 Exact check: a=3, b=3, mode=0, clr=1 -> out_acc=9 two cycles later, out_count=1.
REQ-032 Approximate check: a=3, b=3, mode=1, clr=1 -> out_acc=7; a=255, b=255, mode=1, clr=1 -> out_acc=64927 (exact result is 65025).
REQ-033 Accumulation: beats (10,10,clr=1), (4,5,clr=0), (2,3,clr=0), exact mode -> out_acc sequence 100, 120, 126; out_count sequence 1, 2, 3.
REQ-034 Saturation with ACC_W=16: two beats 255*255 exact, first with clr=1 -> 65025 then 65535 with out_sat=1; a following clr beat 1*1 -> out_acc=1, out_sat=0.
REQ-035 Backpressure: 4 back-to-back beats with out_ready held at 0 for 3 cycles -> in_ready=0 and outputs stable during the stall; all 4 results delivered in order with none lost.
REQ-036 Reset: rst_n=0 while 2 beats are in flight -> out_valid=0, out_acc=0, out_count=0 on the next cycle; no stale result appears afterwards.
